// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit processor.
//   - state_t: sequencer FSM states, 3-bit encoding exposed on the debug port
//   - opcode constants for the upper nibble of the instruction word
//   - PC_W_DEF: default program-counter width
//   - is_wait_state(): states that hold a memory request until ready
package cpu_pkg;

    localparam int PC_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_SUM = 4'b0100;
    localparam logic [3:0] OP_SMI = 4'b1100;

    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// seq_wait_timer: counts cycles spent waiting on a memory handshake and
// flags a timeout once TIMEOUT_CYC consecutive cycles passed without ready.
// Only instantiated when SEQ_TIMEOUT_EN is defined.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   i_active     sequencer is in a handshake state (FETCH or MEM)
//   i_ready      handshake ready for the active request
//   i_clear      sequencer changes state this cycle; restart the count
//   o_timeout    this is the final allowed wait cycle; abandon the request
module seq_wait_timer #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_active,
    input  logic i_ready,
    input  logic i_clear,
    output logic o_timeout
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clear || !i_active || i_ready)
            r_cnt <= 8'd0;
        else
            r_cnt <= r_cnt + 8'd1;
    end

    // r_cnt holds the number of wait cycles already spent, so the
    // TIMEOUT_CYC-th waiting cycle is the one where it equals LIMIT.
    assign o_timeout = i_active && !i_ready && (r_cnt == LIMIT);

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute/memory/writeback FSM.
// Drives the PC and instruction fetch handshake, latches IR for the
// Control_Unit, then sequences alu_en, the data-memory handshake, rf_we
// and retire based on the decoded flags returned from the Control_Unit.
// Optional macro SEQ_TIMEOUT_EN: abandon a handshake after TIMEOUT_CYC
// wait cycles and set the sticky seq_err flag; otherwise wait forever.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   run                        permits a new fetch (IDLE and retire point)
//   imem_req/addr/rdata/ready  instruction fetch handshake
//   ir                         latched instruction
//   dec_mem_read/write/reg_write  decoded flags from the Control_Unit
//   alu_en                     one-cycle execute strobe
//   dmem_req/we/ready          data-memory handshake
//   rf_we                      one-cycle register write strobe
//   retire                     one-cycle instruction-complete pulse
//   pc, state                  program counter and FSM encoding (debug)
//   seq_err                    sticky handshake timeout flag
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W        = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              TIMEOUT_CYC = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_rdata,
    input  logic            imem_ready,
    output logic [7:0]      ir,
    input  logic            dec_mem_read,
    input  logic            dec_mem_write,
    input  logic            dec_reg_write,
    output logic            alu_en,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic            rf_we,
    output logic            retire,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      state,
    output logic            seq_err
);

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
    logic            w_accept;
    logic            w_timeout;

    // Instruction-complete target: run is sampled only here and in IDLE.
    state_t          w_after_retire;
    assign w_after_retire = run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= 8'h00;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ir <= imem_rdata;
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        alu_en   = 1'b0;
        rf_we    = 1'b0;
        retire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (w_timeout) begin
                    w_next = S_IDLE;
                end else if (imem_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (dec_mem_read || dec_mem_write) begin
                    w_next = S_MEM;
                end else if (dec_reg_write) begin
                    w_next = S_WB;
                end else begin
                    retire = 1'b1;
                    w_next = w_after_retire;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                // A write flag wins when both read and write are decoded.
                dmem_we  = dec_mem_write;
                if (w_timeout) begin
                    w_next = S_IDLE;
                end else if (dmem_ready) begin
                    if (dec_reg_write) begin
                        w_next = S_WB;
                    end else begin
                        retire = 1'b1;
                        w_next = w_after_retire;
                    end
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                retire = 1'b1;
                w_next = w_after_retire;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef SEQ_TIMEOUT_EN
    logic w_wait_ready;
    logic w_state_change;
    logic r_seq_err;

    assign w_wait_ready   = (r_state == S_FETCH) ? imem_ready : dmem_ready;
    assign w_state_change = (w_next != r_state);

    seq_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_active  (is_wait_state(r_state)),
        .i_ready   (w_wait_ready),
        .i_clear   (w_state_change),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_seq_err <= 1'b0;
        else if (w_timeout)
            r_seq_err <= 1'b1;
    end

    assign seq_err = r_seq_err;
`else
    // Timeouts are compiled out; this compare is constant false for any
    // legal TIMEOUT_CYC and only keeps the parameter referenced.
    assign w_timeout = (TIMEOUT_CYC < 0);
    assign seq_err   = 1'b0;
`endif

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign state     = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       imem_ready;
    logic [7:0] ir;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_reg_write;
    logic       alu_en;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ready;
    logic       rf_we;
    logic       retire;
    logic [7:0] pc;
    logic [2:0] state;
    logic       seq_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] imem [256];
    assign imem_rdata = imem[imem_addr];

    always #5 clk = ~clk;

    instr_sequencer #(
        .PC_W        (8),
        .RESET_PC    (8'h00),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .ir            (ir),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_reg_write (dec_reg_write),
        .alu_en        (alu_en),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ready    (dmem_ready),
        .rf_we         (rf_we),
        .retire        (retire),
        .pc            (pc),
        .state         (state),
        .seq_err       (seq_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic mr, input logic mw, input logic rw);
        dec_mem_read  = mr;
        dec_mem_write = mw;
        dec_reg_write = rw;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0;
        tick(); tick();
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++;
        if (pc !== 8'h00 || ir !== 8'h00) begin errors++; $display("FAIL reset_pc_ir: got pc=%h ir=%h want 00/00", pc, ir); end
        checks++;
        if ({imem_req, dmem_req, dmem_we, alu_en, rf_we, retire, seq_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 0000000", {imem_req, dmem_req, dmem_we, alu_en, rf_we, retire, seq_err});
        end
    endtask

    // SUM-like op with mr=mw=1, rw=0: F, D, E, M(write, retire), then FETCH.
    task automatic test_sum_store();
        imem[0] = 8'h46; imem_ready = 1'b1; dmem_ready = 1'b1;
        set_flags(1'b1, 1'b1, 1'b0);
        reset = 1'b1; run = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (state !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++; $display("FAIL sum_fetch: got st=%0d req=%b addr=%h want 1/1/00", state, imem_req, imem_addr);
        end
        tick();
        checks++;
        if (state !== 3'd2 || ir !== 8'h46 || pc !== 8'h01) begin
            errors++; $display("FAIL sum_decode: got st=%0d ir=%h pc=%h want 2/46/01", state, ir, pc);
        end
        tick();
        checks++;
        if (state !== 3'd3 || alu_en !== 1'b1 || retire !== 1'b0) begin
            errors++; $display("FAIL sum_exec: got st=%0d alu=%b ret=%b want 3/1/0", state, alu_en, retire);
        end
        tick();
        checks++;
        if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || retire !== 1'b1 || rf_we !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL sum_mem: got st=%0d dreq=%b we=%b ret=%b rf=%b ireq=%b want 4/1/1/1/0/0",
                               state, dmem_req, dmem_we, retire, rf_we, imem_req);
        end
        tick();
        checks++;
        if (state !== 3'd1 || retire !== 1'b0 || alu_en !== 1'b0 || imem_addr !== 8'h01) begin
            errors++; $display("FAIL sum_next: got st=%0d ret=%b alu=%b addr=%h want 1/0/0/01", state, retire, alu_en, imem_addr);
        end
    endtask

    // LD with dmem_ready arriving on the fourth MEM cycle: 8 cycles total.
    task automatic test_load_wait();
        int n_req = 0, n_we = 0, n_rf = 0, n_ret = 0, rf_cyc = 0, ret_cyc = 0, n_both = 0;
        imem[1] = 8'h05;
        set_flags(1'b1, 1'b0, 1'b1);
        dmem_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 7) dmem_ready = 1'b1;
            if (dmem_req) n_req++;
            if (dmem_we) n_we++;
            if (imem_req && dmem_req) n_both++;
            if (rf_we) begin n_rf++; rf_cyc = c; end
            if (retire) begin n_ret++; ret_cyc = c; end
            tick();
        end
        checks++;
        if (n_req !== 4 || n_we !== 0 || n_both !== 0) begin
            errors++; $display("FAIL ld_dmem_req: got req=%0d we=%0d both=%0d want 4/0/0", n_req, n_we, n_both);
        end
        checks++;
        if (n_rf !== 1 || rf_cyc !== 8) begin
            errors++; $display("FAIL ld_rf_we: got count=%0d cycle=%0d want 1/8", n_rf, rf_cyc);
        end
        checks++;
        if (n_ret !== 1 || ret_cyc !== 8) begin
            errors++; $display("FAIL ld_retire: got count=%0d cycle=%0d want 1/8", n_ret, ret_cyc);
        end
        checks++;
        if (state !== 3'd1 || pc !== 8'h02 || ir !== 8'h05) begin
            errors++; $display("FAIL ld_after: got st=%0d pc=%h ir=%h want 1/02/05", state, pc, ir);
        end
    endtask

    // No memory, no writeback: retires in EXEC, three cycles per op.
    task automatic test_no_mem();
        set_flags(1'b0, 1'b0, 1'b0);
        tick(); tick();
        checks++;
        if (state !== 3'd3 || alu_en !== 1'b1 || retire !== 1'b1 || rf_we !== 1'b0 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL nomem_exec: got st=%0d alu=%b ret=%b rf=%b dreq=%b want 3/1/1/0/0",
                               state, alu_en, retire, rf_we, dmem_req);
        end
        tick();
        checks++;
        if (state !== 3'd1 || pc !== 8'h03) begin
            errors++; $display("FAIL nomem_next: got st=%0d pc=%h want 1/03", state, pc);
        end
    endtask

    task automatic test_pc_wrap();
        int n = 0;
        while (!(state == 3'd1 && pc == 8'hFF) && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++; $display("FAIL wrap_reach: got pc=%h st=%0d after %0d cycles want pc=FF in FETCH", pc, state, n);
        end
        checks++;
        if (imem_addr !== 8'hFF || imem_req !== 1'b1) begin
            errors++; $display("FAIL wrap_addr_ff: got addr=%h req=%b want FF/1", imem_addr, imem_req);
        end
        tick();
        checks++;
        if (pc !== 8'h00 || state !== 3'd2) begin
            errors++; $display("FAIL wrap_pc: got pc=%h st=%0d want 00/2", pc, state);
        end
        tick(); tick();
        checks++;
        if (state !== 3'd1 || imem_addr !== 8'h00) begin
            errors++; $display("FAIL wrap_next_addr: got st=%0d addr=%h want 1/00", state, imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        set_flags(1'b1, 1'b0, 1'b1);
        dmem_ready = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (state !== 3'd4 || dmem_req !== 1'b1) begin
            errors++; $display("FAIL mid_in_mem: got st=%0d dreq=%b want 4/1", state, dmem_req);
        end
        reset = 1'b1; run = 1'b0;
        tick();
        checks++;
        if (state !== 3'd0 || dmem_req !== 1'b0 || pc !== 8'h00 || retire !== 1'b0 || rf_we !== 1'b0 || ir !== 8'h00) begin
            errors++; $display("FAIL mid_reset: got st=%0d dreq=%b pc=%h ret=%b rf=%b ir=%h want 0/0/00/0/0/00",
                               state, dmem_req, pc, retire, rf_we, ir);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (state !== 3'd0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL mid_idle_hold: got st=%0d ireq=%b want 0/0", state, imem_req);
        end
    endtask

    task automatic test_run_drop();
        int n_ireq = 0;
        set_flags(1'b0, 1'b0, 1'b1);
        imem_ready = 1'b1; dmem_ready = 1'b1;
        run = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (state !== 3'd3 || alu_en !== 1'b1) begin
            errors++; $display("FAIL drop_exec: got st=%0d alu=%b want 3/1", state, alu_en);
        end
        run = 1'b0;
        tick();
        checks++;
        if (state !== 3'd5 || rf_we !== 1'b1 || retire !== 1'b1) begin
            errors++; $display("FAIL drop_wb: got st=%0d rf=%b ret=%b want 5/1/1", state, rf_we, retire);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            if (imem_req || state != 3'd0) n_ireq++;
            tick();
        end
        checks++;
        if (n_ireq !== 0 || retire !== 1'b0) begin
            errors++; $display("FAIL drop_idle: got busy_cycles=%0d ret=%b want 0/0", n_ireq, retire);
        end
        run = 1'b1;
        tick();
        checks++;
        if (state !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 8'h01) begin
            errors++; $display("FAIL drop_resume: got st=%0d ireq=%b addr=%h want 1/1/01", state, imem_req, imem_addr);
        end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        logic [7:0] pc_before;
        imem_ready = 1'b0;
        pc_before  = pc;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 15) begin
            errors++; $display("FAIL timeout_len: got %0d req cycles want 15", n);
        end
        checks++;
        if (state !== 3'd0 || seq_err !== 1'b1 || pc !== pc_before || retire !== 1'b0) begin
            errors++; $display("FAIL timeout_state: got st=%0d err=%b pc=%h ret=%b want 0/1/%h/0",
                               state, seq_err, pc, retire, pc_before);
        end
    endtask
`else
    task automatic test_timeout();
        int n_bad = 0;
        imem_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (state != 3'd1 || imem_req !== 1'b1 || seq_err !== 1'b0) n_bad++;
            tick();
        end
        checks++;
        if (n_bad !== 0) begin
            errors++; $display("FAIL wait_forever: got %0d cycles off FETCH or seq_err set, want 0", n_bad);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        reset = 1'b1; run = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0);
        test_reset();
        test_sum_store();
        test_load_wait();
        test_no_mem();
        test_pc_wrap();
        test_reset_mid();
        test_run_drop();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
